// File: rtl/jt12_acc_sched.sv
// Slot sequencer for the FM left/right accumulators: walks the 24 operator slots,
// drives zero/sum_en/pcm_sel/snd_stb and double-buffers per-channel alg/pan/dac config.
module jt12_acc_sched #(
    parameter logic [2:0] ALG_RST = 3'd0,
    parameter logic [1:0] PAN_RST = 2'b11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_en,
    input  logic       cfg_we,
    input  logic [2:0] cfg_ch,
    input  logic [2:0] cfg_alg,
    input  logic [1:0] cfg_pan,
    input  logic       dac_en,
    output logic [4:0] slot,
    output logic [2:0] ch,
    output logic [1:0] op,
    output logic       zero,
    output logic       sum_en_l,
    output logic       sum_en_r,
    output logic       pcm_sel,
    output logic       snd_stb
);

    typedef enum logic [1:0] {
        OP_S1 = 2'd0,
        OP_S2 = 2'd1,
        OP_S3 = 2'd2,
        OP_S4 = 2'd3
    } op_e;

    logic [4:0] slot_q, slot_d;
    logic [2:0] ch_q, ch_d;
    op_e        op_q, op_d;
    logic       zero_q, zero_d;
    logic       suml_q, suml_d;
    logic       sumr_q, sumr_d;
    logic       pcm_q, pcm_d;
    logic       stb_q, stb_d;

    logic [2:0] sh_alg_q  [0:5];
    logic [1:0] sh_pan_q  [0:5];
    logic [2:0] act_alg_q [0:5];
    logic [1:0] act_pan_q [0:5];
    logic       sh_dac_q;
    logic       act_dac_q;

    logic       wrap;
    logic [2:0] alg_e;
    logic [1:0] pan_e;
    logic       dac_e;
    logic       dac_slot;
    logic       carrier;

    function automatic logic is_carrier(input logic [2:0] alg, input op_e o);
        logic c;
        c = 1'b0;
        case (alg)
            3'd4:       c = (o == OP_S2) || (o == OP_S4);
            3'd5, 3'd6: c = (o != OP_S1);
            3'd7:       c = 1'b1;
            default:    c = (o == OP_S4);
        endcase
        return c;
    endfunction

    assign wrap = (slot_q == 5'd23);

    always_comb begin
        slot_d   = slot_q;
        ch_d     = ch_q;
        op_d     = op_q;
        zero_d   = zero_q;
        suml_d   = suml_q;
        sumr_d   = sumr_q;
        pcm_d    = pcm_q;
        stb_d    = stb_q;
        alg_e    = '0;
        pan_e    = '0;
        dac_e    = 1'b0;
        dac_slot = 1'b0;
        carrier  = 1'b0;
        if (clk_en) begin
            slot_d = wrap ? '0 : slot_q + 5'd1;
            ch_d   = (ch_q == 3'd5) ? '0 : ch_q + 3'd1;
            // operator groups advance every 6 slots in the order S1, S3, S2, S4
            if (ch_q == 3'd5) begin
                case (op_q)
                    OP_S1:   op_d = OP_S3;
                    OP_S3:   op_d = OP_S2;
                    OP_S2:   op_d = OP_S4;
                    default: op_d = OP_S1;
                endcase
            end
            // slot 0 is computed from the shadows, which become active on this same edge
            alg_e    = wrap ? sh_alg_q[ch_d] : act_alg_q[ch_d];
            pan_e    = wrap ? sh_pan_q[ch_d] : act_pan_q[ch_d];
            dac_e    = wrap ? sh_dac_q : act_dac_q;
            dac_slot = dac_e && (ch_d == 3'd5);
            carrier  = dac_slot ? (op_d == OP_S4) : is_carrier(alg_e, op_d);
            suml_d   = carrier & pan_e[1];
            sumr_d   = carrier & pan_e[0];
            pcm_d    = dac_slot && (op_d == OP_S4);
            zero_d   = (slot_d == 5'd0);
            stb_d    = (slot_d == 5'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q    <= 5'd23;
            ch_q      <= 3'd5;
            op_q      <= OP_S4;
            zero_q    <= 1'b0;
            suml_q    <= 1'b0;
            sumr_q    <= 1'b0;
            pcm_q     <= 1'b0;
            stb_q     <= 1'b0;
            sh_dac_q  <= 1'b0;
            act_dac_q <= 1'b0;
            for (int unsigned i = 0; i < 6; i++) begin
                sh_alg_q[i]  <= ALG_RST;
                sh_pan_q[i]  <= PAN_RST;
                act_alg_q[i] <= ALG_RST;
                act_pan_q[i] <= PAN_RST;
            end
        end else begin
            slot_q <= slot_d;
            ch_q   <= ch_d;
            op_q   <= op_d;
            zero_q <= zero_d;
            suml_q <= suml_d;
            sumr_q <= sumr_d;
            pcm_q  <= pcm_d;
            stb_q  <= stb_d;
            if (clk_en && wrap) begin
                act_dac_q <= sh_dac_q;
                for (int unsigned i = 0; i < 6; i++) begin
                    act_alg_q[i] <= sh_alg_q[i];
                    act_pan_q[i] <= sh_pan_q[i];
                end
            end
            if (cfg_we && (cfg_ch <= 3'd5)) begin
                sh_alg_q[cfg_ch] <= cfg_alg;
                sh_pan_q[cfg_ch] <= cfg_pan;
            end
            sh_dac_q <= dac_en;
        end
    end

    assign slot     = slot_q;
    assign ch       = ch_q;
    assign op       = op_q;
    assign zero     = zero_q;
    assign sum_en_l = suml_q;
    assign sum_en_r = sumr_q;
    assign pcm_sel  = pcm_q;
    assign snd_stb  = stb_q;

endmodule

// File: tb/tb_jt12_acc_sched.sv
// Bench for jt12_acc_sched: slot-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_jt12_acc_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_en = 1'b0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_ch = '0;
    logic [2:0] cfg_alg = '0;
    logic [1:0] cfg_pan = '0;
    logic       dac_en = 1'b0;
    logic [4:0] slot;
    logic [2:0] ch;
    logic [1:0] op;
    logic       zero, sum_en_l, sum_en_r, pcm_sel, snd_stb;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    jt12_acc_sched #(.ALG_RST(3'd0), .PAN_RST(2'b11)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_alg(cfg_alg), .cfg_pan(cfg_pan), .dac_en(dac_en), .slot(slot), .ch(ch),
        .op(op), .zero(zero), .sum_en_l(sum_en_l), .sum_en_r(sum_en_r),
        .pcm_sel(pcm_sel), .snd_stb(snd_stb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: round position plus shadow/active configuration tables
    int m_slot;
    bit m_run;
    int m_sh_alg [6], m_sh_pan [6], m_act_alg [6], m_act_pan [6];
    bit m_sh_dac, m_act_dac;

    always @(posedge clk) begin
        if (rst) begin
            m_slot = 23;
            m_run = 0;
            m_sh_dac = 0;
            m_act_dac = 0;
            for (int i = 0; i < 6; i++) begin
                m_sh_alg[i] = 0; m_sh_pan[i] = 3;
                m_act_alg[i] = 0; m_act_pan[i] = 3;
            end
        end else begin
            if (clk_en) begin
                m_slot = (m_slot + 1) % 24;
                m_run = 1;
                if (m_slot == 0) begin
                    m_act_alg = m_sh_alg;
                    m_act_pan = m_sh_pan;
                    m_act_dac = m_sh_dac;
                end
            end
            if (cfg_we && cfg_ch < 6) begin
                m_sh_alg[cfg_ch] = int'(cfg_alg);
                m_sh_pan[cfg_ch] = int'(cfg_pan);
            end
            m_sh_dac = dac_en;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            int e_ch, e_op, alg, pan, l, r, pcm;
            bit carr;
            int op_of_group [4];
            int mask;
            op_of_group = '{0, 2, 1, 3};
            e_ch = m_slot % 6;
            e_op = op_of_group[m_slot / 6];
            alg = m_act_alg[e_ch];
            pan = m_act_pan[e_ch];
            case (alg)
                4:       mask = 4'b1010;
                5, 6:    mask = 4'b1110;
                7:       mask = 4'b1111;
                default: mask = 4'b1000;
            endcase
            if (m_act_dac && e_ch == 5) begin
                carr = (e_op == 3);
                pcm = (e_op == 3) ? 1 : 0;
            end else begin
                carr = mask[e_op];
                pcm = 0;
            end
            l = (carr && pan[1]) ? 1 : 0;
            r = (carr && pan[0]) ? 1 : 0;
            if (!m_run) begin
                l = 0; r = 0; pcm = 0;
            end
            chk("m_slot", slot, m_slot);
            chk("m_ch", ch, e_ch);
            chk("m_op", op, e_op);
            chk("m_zero", zero, (m_run && m_slot == 0) ? 1 : 0);
            chk("m_stb", snd_stb, (m_run && m_slot == 1) ? 1 : 0);
            chk("m_sum_l", sum_en_l, l);
            chk("m_sum_r", sum_en_r, r);
            chk("m_pcm", pcm_sel, pcm);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input int c, input int a, input int p);
        cfg_we = 1'b1;
        cfg_ch = 3'(c);
        cfg_alg = 3'(a);
        cfg_pan = 2'(p);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_slot", slot, 23);
        chk("rst_ch", ch, 5);
        chk("rst_op", op, 3);
        chk("rst_strobes", {zero, sum_en_l, sum_en_r, pcm_sel, snd_stb}, 0);
        chk_on = 1'b1;
        rst = 1'b0;
        clk_en = 1'b1;

        // Round 1: defaults; ch2 config written mid-round
        for (int i = 0; i < 24; i++) begin
            tick();
            chk("seq_slot", slot, i);
            chk("def_sum_l", sum_en_l, (i >= 18) ? 1 : 0);
            chk("def_zero", zero, (i == 0) ? 1 : 0);
            if (i == 5) wr(2, 7, 2'b10);
            else cfg_we = 1'b0;
        end
        // Round 2: ch2 alg7 pan10 active; ch0 write on the edge entering slot 0
        for (int i = 0; i < 24; i++) begin
            tick();
            if (i == 0) chk("wrap_zero", zero, 1);
            if (i == 1) chk("stb_slot1", snd_stb, 1);
            if (i % 6 == 2) begin
                chk("ch2_sum_l", sum_en_l, 1);
                chk("ch2_sum_r", sum_en_r, 0);
            end
            if (i == 23) wr(0, 4, 2'b11);
        end
        // Round 3: ch0 still alg0; DAC and ch5 config written
        for (int i = 0; i < 24; i++) begin
            tick();
            cfg_we = 1'b0;
            if (i == 12) chk("ch0_old_s2", sum_en_l, 0);
            if (i == 18) chk("ch0_old_s4", sum_en_l, 1);
            if (i == 3) begin
                dac_en = 1'b1;
                wr(5, 7, 2'b01);
            end
        end
        // Round 4: ch0 alg4 active, DAC on channel 6
        for (int i = 0; i < 24; i++) begin
            tick();
            if (i == 12) chk("ch0_new_s2", sum_en_l, 1);
            if (i == 5 || i == 11 || i == 17)
                chk("dac_mute", {sum_en_l, sum_en_r}, 0);
            if (i == 22) chk("pcm_off", pcm_sel, 0);
            if (i == 23) begin
                chk("dac_l", sum_en_l, 0);
                chk("dac_r", sum_en_r, 1);
                chk("dac_pcm", pcm_sel, 1);
            end
        end
        dac_en = 1'b0;

        // Sparse clk_en: outputs hold between enabled edges
        for (int k = 0; k < 300 && slot != 5'd9; k++) begin
            logic [4:0] s;
            logic en;
            en = (k % 6 == 0);
            clk_en = en;
            s = slot;
            tick();
            if (!en) chk("hold_slot", slot, s);
        end
        chk("reach_slot9", slot, 9);
        clk_en = 1'b0;
        wr(1, 7, 2'b11);
        tick();
        cfg_we = 1'b0;
        rst = 1'b1;
        clk_en = 1'b1;
        tick();
        chk("mid_rst_slot", slot, 23);
        chk("mid_rst_ch", ch, 5);
        chk("mid_rst_op", op, 3);
        chk("mid_rst_strobes", {zero, sum_en_l, sum_en_r, pcm_sel, snd_stb}, 0);
        rst = 1'b0;

        // Pending ch1 write discarded; then a cfg_ch=6 write must change nothing
        for (int i = 0; i < 24; i++) begin
            tick();
            cfg_we = 1'b0;
            if (i == 1) chk("ch1_discard", sum_en_l, 0);
            if (i == 19) chk("ch1_s4", sum_en_l, 1);
            if (i == 10) wr(6, 7, 2'b11);
        end
        for (int i = 0; i < 48; i++) begin
            tick();
            if (i % 24 == 0) chk("ch6_ign_s1", sum_en_l, 0);
            if (i % 24 == 6) chk("ch6_ign_s3", sum_en_r, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
